spm_driver: RTL

Host-side driver for the serial-parallel multiplier (`spm`). It accepts a parallel operand pair over a valid/ready handshake and presents the multiplicand to `spm.x` in parallel. It streams the multiplier into `spm.y` serially, LSB first, and collects the serial product from `spm.p` into a parallel 2·SIZE-bit word returned over a second valid/ready handshake. It is the opposite end of the `spm` serial interface and sits between the system bus adapter and the `spm` instance.

---
 rtl/spm_driver_if.sv | 27 ++
 rtl/spm_driver.sv | 97 +++++++++
 2 files changed

// File: rtl/spm_driver_if.sv
// Operand/product handshakes plus the serial link to the spm multiplier.
// The driver binds to the slave modport; the host side (bench or adapter) uses master.
interface spm_driver_if #(
   parameter int SIZE = 32
);
   logic                in_valid;
   logic                in_ready;
   logic [SIZE-1:0]     mc;
   logic [SIZE-1:0]     mp;
   logic                out_valid;
   logic                out_ready;
   logic [2*SIZE-1:0]   prod;
   logic                spm_rst;
   logic [SIZE-1:0]     spm_x;
   logic                spm_y;
   logic                spm_p;

   modport slave (
      input  in_valid, mc, mp, out_ready, spm_p,
      output in_ready, out_valid, prod, spm_rst, spm_x, spm_y
   );

   modport master (
      output in_valid, mc, mp, out_ready, spm_p,
      input  in_ready, out_valid, prod, spm_rst, spm_x, spm_y
   );
endinterface

// File: rtl/spm_driver.sv
// Host-side driver for the serial-parallel multiplier: parallel operands in, serial y/p, parallel product out.
// Define SPM_DRIVER_SIGNED_EN to sign-extend the multiplier for a signed spm; otherwise it is zero-extended.
module spm_driver #(
   parameter int SIZE = 32,
   parameter int LAT  = 1
) (
   input  logic          clk,
   input  logic          rst,
   spm_driver_if.slave   bus
);
   localparam int W      = 2 * SIZE;
   localparam int NSHIFT = W + LAT;
   localparam int CW     = $clog2(NSHIFT + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t          state_q;
   logic [W-1:0]    sr_q;
   logic [W-1:0]    sr_d;
   logic [W-1:0]    prod_q;
   logic [W-1:0]    prod_d;
   logic [CW-1:0]   cnt_q;
   logic [SIZE-1:0] spm_x_q;
   logic [W-1:0]    mp_ext_s;

`ifdef SPM_DRIVER_SIGNED_EN
   assign mp_ext_s = {{SIZE{bus.mp[SIZE-1]}}, bus.mp};
`else
   assign mp_ext_s = {{SIZE{1'b0}}, bus.mp};
`endif

   // Product bits arrive LSB first, so they enter at the MSB and walk down.
   always_comb begin
      sr_d   = {1'b0, sr_q[W-1:1]};
      prod_d = {bus.spm_p, prod_q[W-1:1]};
   end

   // Sequencer: accept, one-cycle spm clear, W+LAT shift cycles, hold the result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         sr_q    <= {W{1'b0}};
         prod_q  <= {W{1'b0}};
         cnt_q   <= {CW{1'b0}};
         spm_x_q <= {SIZE{1'b0}};
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  spm_x_q <= bus.mc;
                  sr_q    <= mp_ext_s;
                  prod_q  <= {W{1'b0}};
                  cnt_q   <= {CW{1'b0}};
                  state_q <= CLEAR;
               end
            end
            CLEAR: begin
               state_q <= SHIFT;
            end
            SHIFT: begin
               sr_q <= sr_d;
               // The first LAT cycles only prime the spm pipeline.
               if (cnt_q >= CW'(LAT)) begin
                  prod_q <= prod_d;
               end
               if (cnt_q == CW'(NSHIFT - 1)) begin
                  cnt_q   <= {CW{1'b0}};
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.prod      = prod_q;
   assign bus.spm_x     = spm_x_q;
   assign bus.spm_y     = (state_q == SHIFT) & sr_q[0];
   assign bus.spm_rst   = rst | (state_q == CLEAR);

endmodule
